seq_divider4: RTL and testbench
===============================

SEQ_DIVIDER4 -- requirements
Module: seq_divider4

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The port clk SHALL be an input, 1 bit wide: the single clock, rising-edge active.
REQ-003 The port rst_n SHALL be an input, 1 bit wide: the asynchronous reset, active low.
REQ-004 The port start SHALL be an input, 1 bit wide: request to begin a division, sampled only in IDLE.
REQ-005 The port dividend SHALL be an input, 4 bits wide: unsigned dividend, sampled with start.
REQ-006 The port divisor SHALL be an input, 4 bits wide: unsigned divisor, sampled with start.
REQ-007 The port q SHALL be an output, 4 bits wide: registered quotient of the last completed operation.
REQ-008 The port r SHALL be an output, 4 bits wide: registered remainder of the last completed operation.
REQ-009 The port busy SHALL be an output, 1 bit wide: high while the state is CALC or DONE.
REQ-010 The port done SHALL be an output, 1 bit wide: a one-cycle pulse when q and r become valid.
REQ-011 The port div_by_zero SHALL be an output, 1 bit wide: high with done when the divisor is 0; otherwise low.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 IDLE -> CALC SHALL occur on a rising edge with start=1 and divisor!=0.
- On that edge: dividend and divisor are latched, the 5-bit partial remainder is cleared, and the iteration counter is set to 3.
REQ-014 IDLE -> DONE SHALL occur on a rising edge with start=1 and divisor=0.
- On that edge: q<=4'hF, r<=dividend, div_by_zero<=1.
REQ-015 In CALC, each edge SHALL perform one restoring step, MSB of the dividend first.
- Shift the next dividend bit into the partial remainder.
- Form the trial value = partial remainder + ~{0,divisor} + 1 (5-bit two's-complement subtract, carry-in = 1).
- If the trial bit 4 is 0: keep the trial value and set the quotient bit to 1.
- Otherwise: restore the partial remainder and set the quotient bit to 0.
REQ-016 CALC SHALL last exactly 4 edges; on the 4th edge the state SHALL go to DONE and the final quotient and remainder SHALL load into q and r.
REQ-017 done SHALL be high for exactly the one cycle spent in DONE; DONE -> IDLE SHALL occur unconditionally on the next edge.
REQ-018 Latency SHALL be 5 edges for a nonzero divisor and 1 edge for a zero divisor, counted from the edge that samples start to the cycle in which done=1.
REQ-019 q, r and div_by_zero SHALL hold their values until the next completion or reset; they SHALL NOT change during CALC.
REQ-020 div_by_zero SHALL be cleared when an operation with a nonzero divisor completes.
REQ-021 start while busy=1 SHALL be ignored, including a start in the DONE cycle; a new start SHALL be accepted only in IDLE.
REQ-022 Changes on dividend or divisor after the start edge SHALL NOT affect the operation in progress.
REQ-023 For every dividend/divisor pair with divisor!=0: dividend = q*divisor + r, with r < divisor.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE and q=0, r=0, busy=0, done=0, div_by_zero=0, and clear all internal registers, independent of clk.
REQ-025 Reset asserted mid-CALC SHALL abort the operation with no done pulse; after rst_n releases, the first edge with start=1 SHALL begin a fresh operation.

Verification
REQ-026 The bench SHALL cover: dividend=13, divisor=4, start pulse -> done 5 edges later with q=3, r=1, div_by_zero=0.
REQ-027 The bench SHALL cover: dividend=15, divisor=1 -> q=15, r=0; then dividend=3, divisor=7 -> q=0, r=3; check busy is high for 5 cycles in each.
REQ-028 The bench SHALL cover: dividend=9, divisor=0 -> done 1 edge later with q=4'hF, r=9, div_by_zero=1; a following 6/3 -> q=2, r=0, div_by_zero=0.
REQ-029 The bench SHALL cover: a start of 13/4, then start=1 with 2/1 on the 2nd CALC edge and again in the DONE cycle -> only 13/4 completes (q=3, r=1), with a single done pulse.
REQ-030 The bench SHALL cover: rst_n pulsed low during CALC of 14/3 -> outputs immediately 0 and no done; after release, 14/3 -> q=4, r=2.
REQ-031 The bench SHALL cover: an exhaustive sweep of all 256 dividend/divisor pairs -> REQ-023 holds for each nonzero divisor, and each zero-divisor case matches REQ-014.

Source files
------------

// File: rtl/seq_divider4.sv
// 4-bit unsigned restoring divider: one quotient bit per clock, MSB first.
// A zero divisor bypasses the iteration and reports q=4'hF, r=dividend.
module seq_divider4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic [3:0] q,
    output logic [3:0] r,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] dvd_q, dvd_d;
    logic [3:0] dvs_q, dvs_d;
    logic [3:0] rem_q, rem_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] q_q, q_d;
    logic [3:0] r_q, r_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       dbz_q, dbz_d;
    logic [7:0] step_s;

    // One restoring step. Returns {next partial remainder, next dividend/quotient shift register}.
    // The stored remainder is always below the divisor, so its 5th bit is always zero and is not kept.
    function automatic logic [7:0] restore_step(input logic [3:0] rem,
                                                input logic [3:0] dvd,
                                                input logic [3:0] dvs);
        logic [4:0] shifted;
        logic [4:0] trial;
        shifted = {rem, dvd[3]};
        trial   = shifted + ~{1'b0, dvs} + 5'd1;
        if (trial[4] == 1'b0) begin
            restore_step = {trial[3:0], dvd[2:0], 1'b1};
        end else begin
            restore_step = {shifted[3:0], dvd[2:0], 1'b0};
        end
    endfunction

    assign step_s = restore_step(rem_q, dvd_q, dvs_q);

    // Next-state and next-output logic for the divider FSM.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start == 1'b1) begin
                    busy_d = 1'b1;
                    if (divisor != 4'd0) begin
                        state_d = CALC;
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        rem_d   = 4'd0;
                        cnt_d   = 2'd3;
                    end else begin
                        state_d = DONE;
                        q_d     = 4'hF;
                        r_d     = dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            CALC: begin
                rem_d = step_s[7:4];
                dvd_d = step_s[3:0];
                // The last step's result goes straight to the outputs so done lines up with valid q/r.
                if (cnt_q == 2'd0) begin
                    state_d = DONE;
                    q_d     = step_s[3:0];
                    r_d     = step_s[7:4];
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= 4'd0;
            dvs_q   <= 4'd0;
            rem_q   <= 4'd0;
            cnt_q   <= 2'd0;
            q_q     <= 4'd0;
            r_q     <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign q           = q_q;
    assign r           = r_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider4.sv
// Scoreboard bench for seq_divider4: expected results are queued at launch and
// popped when done is seen; inputs change one time unit after the rising edge.
module tb_seq_divider4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] q;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   n_cmp;
    int   n_err;

    seq_divider4 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .q          (q),
        .r          (r),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        if (b != 4'd0) begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end else begin
            e.q   = 4'hF;
            e.r   = a;
            e.dbz = 1'b1;
        end
        sb.push_back(e);
    endtask

    // Launch one operation, scramble inputs after the start edge, wait for done (bounded).
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          output int lat, output int busy_cnt, output bit seen,
                          output exp_t got, output logic done_after);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 4'($urandom_range(15, 0));
        divisor  = 4'($urandom_range(15, 0));
        lat      = 1;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        seen     = (done === 1'b1);
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy === 1'b1) busy_cnt++;
            seen = (done === 1'b1);
        end
        got = {q, r, div_by_zero};
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
        #1 rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({q, r, busy, done, div_by_zero} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_state: got q=%h r=%h busy=%b done=%b dbz=%b want all zero", q, r, busy, done, div_by_zero);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        last_exp = '0;
    endtask

    task automatic test_basic();
        int lat, bc; bit seen; exp_t got, e; logic da;
        push_exp(4'd13, 4'd4);
        run_op(4'd13, 4'd4, lat, bc, seen, got, da);
        n_cmp++;
        if (!seen) begin
            n_err++; $display("FAIL basic_timeout: got no done want done");
        end else begin
            e = sb.pop_front(); last_exp = e;
            if (got !== e) begin
                n_err++; $display("FAIL basic_result: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b", got.q, got.r, got.dbz, e.q, e.r, e.dbz);
            end
        end
        n_cmp++;
        if (lat != 5) begin n_err++; $display("FAIL basic_latency: got %0d want 5", lat); end
        n_cmp++;
        if (da !== 1'b0) begin n_err++; $display("FAIL basic_done_width: got done=%b after pulse want 0", da); end
    endtask

    task automatic test_extremes();
        logic [3:0] ta [2] = '{4'd15, 4'd3};
        logic [3:0] tb [2] = '{4'd1, 4'd7};
        int lat, bc; bit seen; exp_t got, e; logic da;
        for (int i = 0; i < 2; i++) begin
            push_exp(ta[i], tb[i]);
            run_op(ta[i], tb[i], lat, bc, seen, got, da);
            n_cmp++;
            if (!seen) begin
                n_err++; $display("FAIL extreme_timeout[%0d]: got no done want done", i);
            end else begin
                e = sb.pop_front(); last_exp = e;
                if (got !== e) begin
                    n_err++; $display("FAIL extreme_result[%0d]: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b", i, got.q, got.r, got.dbz, e.q, e.r, e.dbz);
                end
            end
            n_cmp++;
            if (bc != 5) begin n_err++; $display("FAIL extreme_busy[%0d]: got %0d busy cycles want 5", i, bc); end
        end
    endtask

    task automatic test_div_zero();
        logic [3:0] ta [2] = '{4'd9, 4'd6};
        logic [3:0] tb [2] = '{4'd0, 4'd3};
        int want_lat [2] = '{1, 5};
        int lat, bc; bit seen; exp_t got, e; logic da;
        for (int i = 0; i < 2; i++) begin
            push_exp(ta[i], tb[i]);
            run_op(ta[i], tb[i], lat, bc, seen, got, da);
            n_cmp++;
            if (!seen) begin
                n_err++; $display("FAIL dz_timeout[%0d]: got no done want done", i);
            end else begin
                e = sb.pop_front(); last_exp = e;
                if (got !== e) begin
                    n_err++; $display("FAIL dz_result[%0d]: got q=%h r=%0d dbz=%b want q=%h r=%0d dbz=%b", i, got.q, got.r, got.dbz, e.q, e.r, e.dbz);
                end
            end
            n_cmp++;
            if (lat != want_lat[i]) begin n_err++; $display("FAIL dz_latency[%0d]: got %0d want %0d", i, lat, want_lat[i]); end
        end
    endtask

    task automatic test_busy_ignore();
        int dones, first; exp_t got, e;
        dones = 0; first = -1; got = '0;
        push_exp(4'd13, 4'd4);
        dividend = 4'd13; divisor = 4'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 16; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                dones++;
                if (first < 0) begin first = i; got = {q, r, div_by_zero}; end
            end
            if (i == 1 || i == 4) begin
                start = 1'b1; dividend = 4'd2; divisor = 4'd1;
            end else begin
                start = 1'b0;
            end
            if (i == 2) begin
                n_cmp++;
                if ({q, r, div_by_zero} !== last_exp) begin
                    n_err++; $display("FAIL calc_hold: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b", q, r, div_by_zero, last_exp.q, last_exp.r, last_exp.dbz);
                end
            end
        end
        e = sb.pop_front(); last_exp = e;
        n_cmp++;
        if (got !== e) begin
            n_err++; $display("FAIL ignore_result: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b", got.q, got.r, got.dbz, e.q, e.r, e.dbz);
        end
        n_cmp++;
        if (dones != 1 || first != 4) begin
            n_err++; $display("FAIL ignore_done_count: got %0d pulses (first after edge %0d) want 1 after edge 4", dones, first);
        end
        n_cmp++;
        if ({busy, q, r} !== {1'b0, e.q, e.r}) begin
            n_err++; $display("FAIL ignore_final: got busy=%b q=%0d r=%0d want busy=0 q=%0d r=%0d", busy, q, r, e.q, e.r);
        end
    endtask

    task automatic test_reset_mid();
        int dones, lat, bc; bit seen; exp_t got, e; logic da;
        dones = 0;
        dividend = 4'd14; divisor = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({q, r, busy, done, div_by_zero} !== 11'd0) begin
            n_err++; $display("FAIL midreset_clear: got q=%h r=%h busy=%b done=%b dbz=%b want all zero", q, r, busy, done, div_by_zero);
        end
        last_exp = '0;
        repeat (3) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
        @(negedge clk) rst_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
        n_cmp++;
        if (dones != 0) begin n_err++; $display("FAIL midreset_no_done: got %0d pulses want 0", dones); end
        push_exp(4'd14, 4'd3);
        run_op(4'd14, 4'd3, lat, bc, seen, got, da);
        n_cmp++;
        if (!seen) begin
            n_err++; $display("FAIL midreset_timeout: got no done want done");
        end else begin
            e = sb.pop_front(); last_exp = e;
            if (got !== e) begin
                n_err++; $display("FAIL midreset_result: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b", got.q, got.r, got.dbz, e.q, e.r, e.dbz);
            end
        end
    endtask

    task automatic test_sweep();
        int lat, bc, prod; bit seen; exp_t got, e; logic da;
        logic [3:0] a, b;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                a = 4'(ai); b = 4'(bi);
                push_exp(a, b);
                run_op(a, b, lat, bc, seen, got, da);
                n_cmp++;
                if (!seen) begin
                    n_err++; $display("FAIL sweep_timeout %0d/%0d: got no done want done", a, b);
                    void'(sb.pop_front());
                end else begin
                    e = sb.pop_front(); last_exp = e;
                    if (got !== e || lat != ((b == 4'd0) ? 1 : 5)) begin
                        n_err++; $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dbz=%b lat=%0d want q=%0d r=%0d dbz=%b", a, b, got.q, got.r, got.dbz, lat, e.q, e.r, e.dbz);
                    end
                    if (b != 4'd0) begin
                        n_cmp++;
                        prod = int'(got.q) * int'(b) + int'(got.r);
                        if (prod != int'(a) || got.r >= b) begin
                            n_err++; $display("FAIL sweep_identity %0d/%0d: got q*d+r=%0d r=%0d want %0d with r<%0d", a, b, prod, got.r, a, b);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_busy_ignore();
        test_reset_mid();
        test_sweep();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
